// File: rtl/nombre_pkg.sv
// Shared types and constants for the name scroller: state encoding, tape layout
// and the tape lookup used to pick the letter code shown on each digit.
package nombre_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_DEFAULT = 4'hF;
    localparam int         NAME_LEN      = 8;
    localparam int         DIGITS        = 4;
    localparam logic [3:0] POS_MAX       = 4'd12;

    // Tape is DIGITS blanks, the NAME_LEN letters, then DIGITS blanks.
    localparam logic [3:0] TAPE_FIRST = 4'(DIGITS);
    localparam logic [3:0] TAPE_LAST  = 4'(DIGITS + NAME_LEN - 1);

    function automatic logic [3:0] tape_code(input logic [3:0] p,
                                             input logic [1:0] d,
                                             input logic [3:0] blank);
        logic [1:0] off;
        logic [3:0] idx;
        off = 2'd3 - d;
        idx = p + {2'b00, off};
        if (idx >= TAPE_FIRST && idx <= TAPE_LAST)
            tape_code = idx - TAPE_FIRST;
        else
            tape_code = blank;
    endfunction

endpackage

// File: rtl/nombre_scroller_tick_div.sv
// Free-running divider: counts 0..DIV-1 while cnt_en is high and flags the
// terminal count combinationally so the owner can act on the same edge.
module tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt_en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt_en)
            cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/nombre_scroller.sv
// Scrolls the 8-letter name across a 4-digit multiplexed display.
// Define NOMBRE_SCROLL_BOUNCE_EN to make the window bounce between 0 and 12.
//
// state  | meaning
// IDLE   | display blank, pos held at 0
// RUN    | scanning digits and stepping the window
// FREEZE | scanning digits, window position and step count held
module nombre_scroller
    import nombre_pkg::*;
#(
    parameter int         MUX_DIV    = 50000,
    parameter int         STEP_DIV   = 12500000,
    parameter logic [3:0] BLANK_CODE = BLANK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold,
    output logic [3:0] bcd,
    output logic [3:0] an,
    output logic [3:0] pos,
    output logic       wrap
);

    state_t     state, state_nxt;
    logic [1:0] digit;
    logic       scan_clr, scan_en, scan_tick;
    logic       step_clr, step_en, step_tick;
    logic       step_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
                     else if (hold) state_nxt = FREEZE;
            FREEZE:  if (!en) state_nxt = IDLE;
                     else if (!hold) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign scan_clr = (state == IDLE);
    assign scan_en  = (state != IDLE);
    assign step_clr = (state != RUN) && (state_nxt == RUN);
    assign step_en  = (state == RUN);
    // A step landing on the same edge that leaves RUN is dropped.
    assign step_go  = step_tick && (state == RUN) && (state_nxt == RUN);

    tick_div #(.DIV(MUX_DIV)) u_scan_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (scan_clr),
        .cnt_en (scan_en),
        .tick   (scan_tick)
    );

    tick_div #(.DIV(STEP_DIV)) u_step_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (step_clr),
        .cnt_en (step_en),
        .tick   (step_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit <= 2'd3;
        else if (state == IDLE)
            digit <= 2'd3;
        else if (scan_tick)
            digit <= digit - 2'd1;
    end

`ifdef NOMBRE_SCROLL_BOUNCE_EN
    logic dir_rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            wrap    <= 1'b0;
            dir_rev <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (state_nxt == IDLE) begin
                pos     <= '0;
                dir_rev <= 1'b0;
            end else if (step_go) begin
                if (!dir_rev) begin
                    if (pos == POS_MAX) begin
                        pos     <= POS_MAX - 4'd1;
                        dir_rev <= 1'b1;
                        wrap    <= 1'b1;
                    end else begin
                        pos <= pos + 4'd1;
                    end
                end else begin
                    if (pos == 4'd0) begin
                        pos     <= 4'd1;
                        dir_rev <= 1'b0;
                        wrap    <= 1'b1;
                    end else begin
                        pos <= pos - 4'd1;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (state_nxt == IDLE) begin
                pos <= '0;
            end else if (step_go) begin
                if (pos == POS_MAX) begin
                    pos  <= '0;
                    wrap <= 1'b1;
                end else begin
                    pos <= pos + 4'd1;
                end
            end
        end
    end
`endif

    // Blanking on the edge that enters IDLE keeps an/bcd from lagging the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            bcd <= BLANK_CODE;
        end else if (state == IDLE || state_nxt == IDLE) begin
            an  <= 4'b1111;
            bcd <= BLANK_CODE;
        end else begin
            an  <= ~(4'b0001 << digit);
            bcd <= tape_code(pos, digit, BLANK_CODE);
        end
    end

endmodule

// File: tb/tb_nombre_scroller.sv
// Directed bench for nombre_scroller with MUX_DIV = 2, STEP_DIV = 8; expected
// values are queued per cycle and checked by an independent monitor.
module tb_nombre_scroller;

    logic       clk = 1'b0;
    logic       rst_n, en, hold;
    logic [3:0] bcd, an, pos;
    logic       wrap;

    nombre_scroller #(.MUX_DIV(2), .STEP_DIV(8), .BLANK_CODE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .hold  (hold),
        .bcd   (bcd),
        .an    (an),
        .pos   (pos),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

`ifdef NOMBRE_SCROLL_BOUNCE_EN
    localparam logic [3:0] WP = 4'd11, FP = 4'd6, FQ = 4'd5, P24 = 4'd0, P25 = 4'd1;
    localparam logic       W25 = 1'b1;
`else
    localparam logic [3:0] WP = 4'd0, FP = 4'd5, FQ = 4'd6, P24 = 4'd11, P25 = 4'd12;
    localparam logic       W25 = 1'b0;
`endif

    typedef struct {
        int         c;
        string      nm;
        logic [3:0] m;      // compare mask: [3]=an [2]=bcd [1]=pos [0]=wrap
        logic [3:0] a, b, p;
        logic       w;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] tp(input int i);
        if (i >= 4 && i <= 11) return 4'(i - 4);
        return 4'hF;
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [3:0] m,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] p, input logic w);
        exp_t e;
        e.c = c; e.nm = nm; e.m = m; e.a = a; e.b = b; e.p = p; e.w = w;
        q.push_back(e);
    endtask

    task automatic expect_win(input int base, input int p, input string nm);
        logic [3:0] sel;
        for (int k = 0; k < 4; k++) begin
            sel = 4'b1000 >> k;
            expect_at(base + 2 * k, nm, 4'hF, ~sel, tp(p + k), 4'(p), 1'b0);
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            me = q.pop_front();
            checks++;
            if (me.c < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cyc %0d missed at cyc %0d", me.nm, me.c, cyc);
            end else if ((me.m[3] && an !== me.a) || (me.m[2] && bcd !== me.b) ||
                         (me.m[1] && pos !== me.p) || (me.m[0] && wrap !== me.w)) begin
                errors++;
                $display("FAIL %s cyc %0d: got an=%b bcd=%h pos=%0d wrap=%b, want an=%b bcd=%h pos=%0d wrap=%b (mask %b)",
                         me.nm, cyc, an, bcd, pos, wrap, me.a, me.b, me.p, me.w, me.m);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        hold  = 1'b0;

        for (int c = 1; c <= 3; c++)
            expect_at(c, "reset", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);
        expect_at(4, "run_entry", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);
        expect_win(5, 0, "scan_pos0");
        expect_win(37, 4, "win_pos4");
        expect_win(69, 8, "win_pos8");
        expect_win(101, 12, "win_pos12");
        expect_at(108, "wrap_step", 4'h3, 4'h0, 4'h0, WP, 1'b1);
        expect_at(109, "wrap_pulse_end", 4'h3, 4'h0, 4'h0, WP, 1'b0);
        goto_cyc(3);
        rst_n = 1'b1;

        goto_cyc(150);
        hold = 1'b1;
        expect_at(160, "freeze_pos", 4'h3, 4'h0, 4'h0, FP, 1'b0);
        expect_at(165, "freeze_scan_d3", 4'hF, 4'b0111, tp(int'(FP)), FP, 1'b0);
        expect_at(167, "freeze_scan_d2", 4'hF, 4'b1011, tp(int'(FP) + 1), FP, 1'b0);
        expect_at(190, "freeze_end_pos", 4'h3, 4'h0, 4'h0, FP, 1'b0);
        expect_at(198, "release_no_step", 4'h3, 4'h0, 4'h0, FP, 1'b0);
        expect_at(199, "release_step8", 4'h3, 4'h0, 4'h0, FQ, 1'b0);
        goto_cyc(190);
        hold = 1'b0;

        goto_cyc(206);
        hold = 1'b1;
        expect_at(207, "hold_vs_tick", 4'h3, 4'h0, 4'h0, FQ, 1'b0);
        expect_at(210, "hold_vs_tick_late", 4'h3, 4'h0, 4'h0, FQ, 1'b0);

        goto_cyc(212);
        en = 1'b0;
        expect_at(213, "en_beats_hold", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);
        expect_at(215, "idle_blank", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);

        goto_cyc(220);
        en   = 1'b1;
        hold = 1'b0;
        expect_at(228, "reentry_pos0", 4'h3, 4'h0, 4'h0, 4'd0, 1'b0);
        expect_at(229, "reentry_step", 4'h3, 4'h0, 4'h0, 4'd1, 1'b0);
        expect_at(239, "prereset_scan", 4'h8, 4'b0111, 4'h0, 4'h0, 1'b0);

        goto_cyc(240);
        rst_n = 1'b0;
        expect_at(240, "async_reset", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);
        expect_at(242, "reset_hold", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);

        goto_cyc(243);
        rst_n = 1'b1;
        expect_at(244, "rerun_entry", 4'hF, 4'b1111, 4'hF, 4'd0, 1'b0);
        expect_at(245, "rerun_scan", 4'hF, 4'b0111, 4'hF, 4'd0, 1'b0);
        expect_at(340, "long_pos12", 4'h3, 4'h0, 4'h0, 4'd12, 1'b0);
        expect_at(348, "long_turn", 4'h3, 4'h0, 4'h0, WP, 1'b1);
        expect_at(349, "long_turn_end", 4'h3, 4'h0, 4'h0, WP, 1'b0);
        expect_at(436, "long_n24", 4'h3, 4'h0, 4'h0, P24, 1'b0);
        expect_at(444, "long_n25", 4'h3, 4'h0, 4'h0, P25, W25);

        goto_cyc(460);
        while (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cyc %0d never checked", me.nm, me.c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
